// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared state encoding and constants for the hazard sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    localparam logic       MEM_SEL_FETCH = 1'b0;
    localparam logic       MEM_SEL_DATA  = 1'b1;
    localparam logic [4:0] REG_X0        = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_watchdog.sv
// ============================================================================
// Module   : hazard_watchdog
// Brief    : Loadable up-counter with terminal-count flag and sticky error bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    input  logic i_set_err,
    output logic o_tc,
    output logic o_err
);

    localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

    logic [7:0] r_count;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign o_tc  = (r_count == c_last);
    assign o_err = r_err;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush sequencer and shared memory-port arbiter for RV32 pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    input  logic [4:0]       RIDEX,
    input  logic             IDEX_MemRead,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             Branch_Taken,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             Pipe_Hold,
    output logic             MEMWB_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Mem_Sel,
    output logic             Err,
    output logic [CNT_W-1:0] Stall_Cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_lu;
    logic             w_da;
    logic             w_wd_tc;
    logic             w_done;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_lu   = IDEX_MemRead && (RIDEX != REG_X0) && ((RIDEX == Rs1) || (RIDEX == Rs2));
    assign w_da   = EXMEM_MemRead || EXMEM_MemWrite;
    assign w_done = Mem_Ready || w_wd_tc;

    hazard_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ST_RUN),
        .i_inc     ((r_state == ST_DATA) && !w_done),
        .i_set_err ((r_state == ST_DATA) && w_wd_tc && !Mem_Ready),
        .o_tc      (w_wd_tc),
        .o_err     (Err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        Pipe_Hold   = 1'b0;
        MEMWB_Write = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Mem_Sel     = MEM_SEL_FETCH;

        if (rst) begin
            w_state_nxt = ST_RUN;
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            MEMWB_Write = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A taken branch squashes whatever da/lu the younger slots raised.
                    if (Branch_Taken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Flush  = 1'b1;
                        EXMEM_Flush = 1'b1;
                    end else if (w_da) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        Pipe_Hold   = 1'b1;
                        MEMWB_Write = 1'b0;
                        w_state_nxt = ST_DATA;
                    end else if (w_lu) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                ST_DATA: begin
                    Mem_Sel  = MEM_SEL_DATA;
                    PC_Write = 1'b0;
                    if (w_done) begin
                        // Fetch slot was stolen: IF/ID becomes NOP and PC re-fetches.
                        IFID_Flush  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        IFID_Write  = 1'b0;
                        Pipe_Hold   = 1'b1;
                        MEMWB_Write = 1'b0;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!PC_Write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign Stall_Cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed table-driven bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] ridex;
        logic       imr;
        logic       emr;
        logic       emw;
        logic       br;
        logic       rdy;
    } vin_t;

    typedef struct {
        string       name;
        vin_t        i;
        logic [13:0] o;
    } vec_t;

    // {PC_Write, IFID_Write, Pipe_Hold, MEMWB_Write, IDEX_Bubble,
    //  IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_Sel}
    localparam logic [8:0] P_RST   = 9'b0000_0111_0;
    localparam logic [8:0] P_NORM  = 9'b1101_0000_0;
    localparam logic [8:0] P_LU    = 9'b0001_1000_0;
    localparam logic [8:0] P_DA    = 9'b0010_0000_0;
    localparam logic [8:0] P_BR    = 9'b1101_0111_0;
    localparam logic [8:0] P_DWAIT = 9'b0010_0000_1;
    localparam logic [8:0] P_DDONE = 9'b0101_0100_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1, Rs2, RIDEX;
    logic       IDEX_MemRead, EXMEM_MemRead, EXMEM_MemWrite, Branch_Taken, Mem_Ready;
    logic       PC_Write, IFID_Write, Pipe_Hold, MEMWB_Write, IDEX_Bubble;
    logic       IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_Sel, Err;
    logic [3:0] Stall_Cnt;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Rs1            (Rs1),
        .Rs2            (Rs2),
        .RIDEX          (RIDEX),
        .IDEX_MemRead   (IDEX_MemRead),
        .EXMEM_MemRead  (EXMEM_MemRead),
        .EXMEM_MemWrite (EXMEM_MemWrite),
        .Branch_Taken   (Branch_Taken),
        .Mem_Ready      (Mem_Ready),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .Pipe_Hold      (Pipe_Hold),
        .MEMWB_Write    (MEMWB_Write),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Flush     (IDEX_Flush),
        .EXMEM_Flush    (EXMEM_Flush),
        .Mem_Sel        (Mem_Sel),
        .Err            (Err),
        .Stall_Cnt      (Stall_Cnt)
    );

    function automatic vin_t vi(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] rd, input logic imr, input logic emr,
                                input logic emw, input logic br, input logic rdy);
        vin_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.ridex = rd;
        v.imr = imr; v.emr = emr; v.emw = emw; v.br = br; v.rdy = rdy;
        return v;
    endfunction

    task automatic add(input string nm, input vin_t v, input logic [8:0] p,
                       input logic e, input logic [3:0] c);
        vec_t x;
        x.name = nm; x.i = v; x.o = {p, e, c};
        vecs.push_back(x);
    endtask

    task automatic drive(input vin_t v);
        rst = v.rst; Rs1 = v.rs1; Rs2 = v.rs2; RIDEX = v.ridex;
        IDEX_MemRead = v.imr; EXMEM_MemRead = v.emr; EXMEM_MemWrite = v.emw;
        Branch_Taken = v.br; Mem_Ready = v.rdy;
    endtask

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    function automatic logic [13:0] outs();
        return {PC_Write, IFID_Write, Pipe_Hold, MEMWB_Write, IDEX_Bubble,
                IFID_Flush, IDEX_Flush, EXMEM_Flush, Mem_Sel, Err, Stall_Cnt};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vin_t idle, lu5;
        idle = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu5  = vi(0, 5, 0, 5, 1, 0, 0, 0, 0);

        add("reset_state",    vi(1, 0, 0, 0, 0, 0, 0, 0, 0), P_RST,   0, 0);
        add("idle",           idle,                            P_NORM,  0, 0);
        add("lu_rs1",         lu5,                             P_LU,    0, 0);
        add("after_lu",       idle,                            P_NORM,  0, 1);
        add("lu_x0",          vi(0, 0, 0, 0, 1, 0, 0, 0, 0),   P_NORM,  0, 1);
        add("lu_rs2",         vi(0, 3, 7, 7, 1, 0, 0, 0, 0),   P_LU,    0, 1);
        add("load_no_dep",    vi(0, 3, 4, 7, 1, 0, 0, 0, 0),   P_NORM,  0, 2);
        add("dep_not_load",   vi(0, 9, 0, 9, 0, 0, 0, 0, 0),   P_NORM,  0, 2);
        add("rd_detect",      vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DA,    0, 2);
        add("rd_wait1",       vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DWAIT, 0, 3);
        add("rd_wait2",       vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DWAIT, 0, 4);
        add("rd_done",        vi(0, 0, 0, 0, 0, 1, 0, 0, 1),   P_DDONE, 0, 5);
        add("rd_back_run",    idle,                            P_NORM,  0, 6);
        add("branch_prio",    vi(0, 5, 0, 5, 1, 0, 1, 1, 0),   P_BR,    0, 6);
        add("after_branch",   idle,                            P_NORM,  0, 6);
        add("wr_detect",      vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DA,    0, 6);
        add("data_ign_br_lu", vi(0, 5, 0, 5, 1, 0, 1, 1, 1),   P_DDONE, 0, 7);
        add("after_ign",      idle,                            P_NORM,  0, 8);
        add("wd_detect",      vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DA,    0, 8);
        add("wd_wait1",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 9);
        add("wd_wait2",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 10);
        add("wd_wait3",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 11);
        add("wd_forced",      vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DDONE, 0, 12);
        add("err_set",        idle,                            P_NORM,  1, 13);
        add("ok_detect",      vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DA,    1, 13);
        add("ok_done",        vi(0, 0, 0, 0, 0, 1, 0, 0, 1),   P_DDONE, 1, 14);
        add("err_sticky",     idle,                            P_NORM,  1, 15);
        add("lu_at_max",      lu5,                             P_LU,    1, 15);
        add("cnt_saturated",  idle,                            P_NORM,  1, 15);
        add("mr_detect",      vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DA,    1, 15);
        add("mr_wait1",       vi(0, 0, 0, 0, 0, 1, 0, 0, 0),   P_DWAIT, 1, 15);
        add("mr_reset",       vi(1, 0, 0, 0, 0, 1, 0, 0, 0),   P_RST,   1, 15);
        add("mr_after_rst",   idle,                            P_NORM,  0, 0);
        add("lu_post_rst",    lu5,                             P_LU,    0, 0);
        add("cnt_post_rst",   idle,                            P_NORM,  0, 1);
        add("tc_detect",      vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DA,    0, 1);
        add("tc_wait1",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 2);
        add("tc_wait2",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 3);
        add("tc_wait3",       vi(0, 0, 0, 0, 0, 0, 1, 0, 0),   P_DWAIT, 0, 4);
        add("tc_with_ready",  vi(0, 0, 0, 0, 0, 0, 1, 0, 1),   P_DDONE, 0, 5);
        add("no_err_ready",   idle,                            P_NORM,  0, 6);
        add("b2b_detect1",    vi(0, 0, 0, 0, 0, 1, 0, 0, 1),   P_DA,    0, 6);
        add("b2b_done1",      vi(0, 0, 0, 0, 0, 1, 0, 0, 1),   P_DDONE, 0, 7);
        add("b2b_detect2",    vi(0, 0, 0, 0, 0, 1, 0, 0, 1),   P_DA,    0, 8);
        add("b2b_done2",      vi(0, 0, 0, 0, 0, 0, 0, 0, 1),   P_DDONE, 0, 9);
        add("b2b_end",        idle,                            P_NORM,  0, 10);

        drive(vi(1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            drive(vecs[k].i);
            @(negedge clk);
            chk(vecs[k].name, outs(), vecs[k].o);
        end

        // Continuous load-use: counter climbs one per cycle and pins at 15.
        @(posedge clk); #1;
        drive(vi(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            drive(lu5);
            @(negedge clk);
            chk($sformatf("sat_cnt_%0d", n), {IDEX_Bubble, PC_Write, Stall_Cnt},
                {1'b1, 1'b0, 4'((n < 15) ? n : 15)});
        end
        @(posedge clk); #1;
        drive(idle);
        @(negedge clk);
        chk("sat_final", {10'(0), Stall_Cnt}, {10'(0), 4'd15});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush sequencer for the 5-stage pipelined RV32 core; sits beside the forwarding unit and drives register-write enables and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Arbitrates the single shared memory port between instruction fetch and EX/MEM data access.
- Detects load-use hazards that forwarding cannot cover and squashes younger instructions on a taken branch.
- Provides a memory-completion watchdog and a stall performance counter.

Parameters:
- TIMEOUT, 15: max DATA-state cycles waiting for Mem_Ready before forced completion; legal range 1..255.
- CNT_W, 16: width of the stall cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1  in  5  IF/ID source register 1.
- Rs2  in  5  IF/ID source register 2.
- RIDEX  in  5  ID/EX destination register.
- IDEX_MemRead  in  1  instruction in ID/EX is a load.
- EXMEM_MemRead  in  1  instruction in EX/MEM reads memory.
- EXMEM_MemWrite  in  1  instruction in EX/MEM writes memory.
- Branch_Taken  in  1  branch/jump resolved taken for the instruction in EX/MEM.
- Mem_Ready  in  1  memory completes the current data access this cycle.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- Pipe_Hold  out  1  freezes ID/EX and EX/MEM.
- MEMWB_Write  out  1  MEM/WB load enable.
- IDEX_Bubble  out  1  zero control fields loaded into ID/EX.
- IFID_Flush  out  1  IF/ID loads NOP.
- IDEX_Flush  out  1  ID/EX loads NOP.
- EXMEM_Flush  out  1  EX/MEM loads NOP.
- Mem_Sel  out  1  memory port owner: 0 = fetch, 1 = data.
- Err  out  1  sticky watchdog timeout flag.
- Stall_Cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN (0) and DATA (1), registered. All outputs are combinational from state and inputs; Err and Stall_Cnt are registered.
- Derived signals:
  - lu = IDEX_MemRead & (RIDEX != 0) & (RIDEX == Rs1 | RIDEX == Rs2).
  - da = EXMEM_MemRead | EXMEM_MemWrite.
- While rst = 1:
  - state := RUN, watchdog := 0, Err := 0, Stall_Cnt := 0.
  - Outputs forced to PC_Write = 0, IFID_Write = 0, Pipe_Hold = 0, MEMWB_Write = 0, IDEX_Bubble = 0, all three Flush outputs = 1, Mem_Sel = 0.
  - Reset in mid-DATA abandons the access.
- Defaults, unless overridden by a rule below: PC_Write = 1, IFID_Write = 1, Pipe_Hold = 0, MEMWB_Write = 1, IDEX_Bubble = 0, all Flush outputs = 0, Mem_Sel = 0.
- Rules in RUN, applied in priority order (first match wins):
  1. Branch_Taken: IFID_Flush = IDEX_Flush = EXMEM_Flush = 1, PC_Write = 1 (loads target). Next state RUN. Any concurrent da or lu is ignored, since the flushed instructions are squashed.
  2. da: PC_Write = 0, IFID_Write = 0, Pipe_Hold = 1, MEMWB_Write = 0. Next state DATA, watchdog := 0. The fetch issued in this cycle is discarded and the PC re-fetches later.
  3. lu: PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1. EX/MEM and MEM/WB advance. Next state RUN. This is a one-cycle bubble; lu clears once the load reaches EX/MEM.
- Rules in DATA:
  - Mem_Sel = 1 throughout. Branch_Taken and lu are ignored.
  - Mem_Ready = 0 and watchdog < TIMEOUT-1:
    - PC_Write = 0, IFID_Write = 0, Pipe_Hold = 1, MEMWB_Write = 0.
    - watchdog increments. State stays DATA.
  - Completion (Mem_Ready = 1, or watchdog == TIMEOUT-1):
    - Pipe_Hold = 0, MEMWB_Write = 1, PC_Write = 0, IFID_Flush = 1.
    - The IF/ID instruction moves to ID/EX, IF/ID becomes NOP, and the PC re-fetches next cycle.
    - Next state RUN.
    - If completion is forced by the watchdog without Mem_Ready, Err := 1 and stays 1 until rst.
- Stall_Cnt:
  - Increments, saturating at all-ones, in every non-reset cycle where PC_Write = 0.
  - The reset cycle itself does not count.
- Minimum data access: two cycles (RUN-detect plus one DATA cycle with Mem_Ready = 1).
- A stream of back-to-back memory ops re-enters DATA each time the next one reaches EX/MEM.

Decomposition:
- Shared package holds:
  - state encoding constants ST_RUN = 0, ST_DATA = 1;
  - MEM_SEL_FETCH = 0, MEM_SEL_DATA = 1;
  - the x0 register index constant.
- Sub-module: hazard_watchdog, a loadable up-counter with terminal-count flag plus the sticky Err register, parameterised by TIMEOUT. Everything else is inline.

Test Plan:
- Load-use: IDEX_MemRead = 1, RIDEX = 5, Rs1 = 5, no da/branch -> PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1 for 1 cycle, Stall_Cnt = 1. Repeat with RIDEX = 0 -> no stall.
- Data access with Mem_Ready on 3rd DATA cycle, EXMEM_MemRead = 1:
  - Cycle 0 (RUN): Pipe_Hold = 1.
  - Cycles 1-2: Mem_Sel = 1, Pipe_Hold = 1, MEMWB_Write = 0.
  - Cycle 3: MEMWB_Write = 1, IFID_Flush = 1, PC_Write = 0.
  - Cycle 4: RUN, Mem_Sel = 0.
  - Stall_Cnt = 4.
- Branch priority: Branch_Taken = 1 together with lu and EXMEM_MemWrite = 1 in RUN -> all three Flush = 1, PC_Write = 1, next state RUN, no bubble.
- Watchdog: TIMEOUT = 4, EXMEM_MemWrite = 1, Mem_Ready held 0 -> forced completion on the 4th DATA cycle, Err = 1, and Err stays 1 after later normal accesses until rst.
- Reset mid-DATA: assert rst on 2nd DATA cycle -> that cycle all Flush = 1 and PC_Write = 0; next cycle state RUN, Mem_Sel = 0, Stall_Cnt = 0, Err = 0.
- Saturation: CNT_W = 4, hold continuous lu for 20 cycles -> Stall_Cnt stops at 15.
